// File: rtl/sat_cnt_arbiter.sv
// rtl/sat_cnt_arbiter.sv - round-robin arbiter updating a shared saturating counter (SAT_CNT_ARBITER_WRAP_EN selects wrapping)
module sat_cnt_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic [N_REQ-1:0]   i_req,
    input  logic [4*N_REQ-1:0] i_step,
    output logic [N_REQ-1:0]   o_gnt,
    output logic [N_REQ-1:0]   o_ack,
    output logic [WIDTH-1:0]   o_count,
    output logic               o_full,
    output logic               o_busy
);

    localparam int               IDX_W    = $clog2(N_REQ);
    localparam logic [WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_APPLY
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] win_q;
    logic [IDX_W-1:0] last_q;
    logic [3:0]       step_q;

    logic [N_REQ-1:0] win_onehot;
    logic [N_REQ-1:0] req_cand;
    logic             arb_found;
    logic [IDX_W-1:0] arb_idx;
    logic [IDX_W-1:0] cand;
    logic [3:0]       arb_step;
    logic [WIDTH-1:0] count_next;

    assign win_onehot = N_REQ'(1) << win_q;

    // The requester being acked is excluded so a held request cannot win twice in a row
    assign req_cand = (state == ST_APPLY) ? (i_req & ~win_onehot) : i_req;

    // Round-robin search starting just after the last granted index
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        arb_step  = '0;
        cand      = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = IDX_W'((int'(last_q) + i) % N_REQ);
            if (!arb_found && req_cand[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
        for (int r = 0; r < N_REQ; r++) begin
            if (arb_idx == IDX_W'(r)) begin
                arb_step = i_step[4*r +: 4];
            end
        end
    end

`ifdef SAT_CNT_ARBITER_WRAP_EN
    // Modulo update: carry out of the top bit is simply dropped
    always_comb begin
        count_next = o_count + WIDTH'(step_q);
    end
`else
    logic [WIDTH:0] sum;

    // Sum at one extra bit so overflow is visible, then clamp to all-ones
    always_comb begin
        sum        = {1'b0, o_count} + (WIDTH+1)'(step_q);
        count_next = sum[WIDTH] ? CNT_MAX : sum[WIDTH-1:0];
    end
`endif

    // Control FSM with registered grant/ack/count/status outputs
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state   <= ST_IDLE;
            win_q   <= '0;
            last_q  <= LAST_RST;
            step_q  <= '0;
            o_gnt   <= '0;
            o_ack   <= '0;
            o_count <= '0;
            o_full  <= 1'b0;
            o_busy  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    o_ack <= '0;
                    if (arb_found) begin
                        state  <= ST_GRANT;
                        win_q  <= arb_idx;
                        last_q <= arb_idx;
                        step_q <= arb_step;
                        o_gnt  <= N_REQ'(1) << arb_idx;
                        o_busy <= 1'b1;
                    end
                end
                ST_GRANT: begin
                    state   <= ST_APPLY;
                    o_gnt   <= '0;
                    o_ack   <= win_onehot;
                    o_count <= count_next;
                    o_full  <= (count_next == CNT_MAX);
                end
                ST_APPLY: begin
                    o_ack <= '0;
                    if (arb_found) begin
                        state  <= ST_GRANT;
                        win_q  <= arb_idx;
                        last_q <= arb_idx;
                        step_q <= arb_step;
                        o_gnt  <= N_REQ'(1) << arb_idx;
                    end else begin
                        state  <= ST_IDLE;
                        o_busy <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    o_gnt <= '0;
                    o_ack <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sat_cnt_arbiter.sv
// tb/tb_sat_cnt_arbiter.sv - self-checking bench for sat_cnt_arbiter
module tb_sat_cnt_arbiter;

    localparam int N = 4;
    localparam int W = 8;
    localparam int MAXV = 255;

`ifdef SAT_CNT_ARBITER_WRAP_EN
    localparam int SAT_EXP1 = 9;
    localparam int SAT_FULL1 = 0;
    localparam int SAT_EXP2 = 12;
    localparam int SAT_FULL2 = 0;
`else
    localparam int SAT_EXP1 = 255;
    localparam int SAT_FULL1 = 1;
    localparam int SAT_EXP2 = 255;
    localparam int SAT_FULL2 = 1;
`endif

    logic          i_clk;
    logic          i_rstn;
    logic [N-1:0]  i_req;
    logic [4*N-1:0] i_step;
    logic [N-1:0]  o_gnt;
    logic [N-1:0]  o_ack;
    logic [W-1:0]  o_count;
    logic          o_full;
    logic          o_busy;

    sat_cnt_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_req   (i_req),
        .i_step  (i_step),
        .o_gnt   (o_gnt),
        .o_ack   (o_ack),
        .o_count (o_count),
        .o_full  (o_full),
        .o_busy  (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] prev_count;

    typedef struct {
        logic [3:0]  req;
        logic [15:0] steps;
        logic [3:0]  gnt;
        logic [7:0]  count;
        logic        full;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one cycle, then check the always-true output relations
    task automatic tick();
        logic rst_seen;
        rst_seen = !i_rstn;
        @(negedge i_clk);
        chk("gnt_onehot0", 32'($onehot0(o_gnt)), 1);
        chk("ack_onehot0", 32'($onehot0(o_ack)), 1);
        chk("full_flag", o_full, (o_count == W'(MAXV)) ? 1 : 0);
`ifndef SAT_CNT_ARBITER_WRAP_EN
        if (!rst_seen) chk("count_mono", (o_count >= prev_count) ? 1 : 0, 1);
`endif
        prev_count = o_count;
    endtask

    task automatic do_reset();
        i_rstn = 1'b0;
        i_req  = '0;
        tick();
        i_rstn = 1'b1;
    endtask

    // Behavioural reference: phase 0 idle, 1 granting, 2 acking
    int m_phase, m_win, m_step, m_last, m_count;

    function automatic int rr_pick(input logic [3:0] r, input int last);
        for (int k = 1; k <= N; k++) begin
            if (r[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic int apply_step(input int c, input int s);
`ifdef SAT_CNT_ARBITER_WRAP_EN
        return (c + s) % (MAXV + 1);
`else
        return (c + s > MAXV) ? MAXV : c + s;
`endif
    endfunction

    task automatic model_advance(input logic rstn, input logic [3:0] req, input logic [15:0] steps);
        logic [3:0] r;
        int w;
        if (!rstn) begin
            m_phase = 0; m_last = N - 1; m_count = 0; m_win = 0; m_step = 0;
        end else if (m_phase == 1) begin
            m_count = apply_step(m_count, m_step);
            m_phase = 2;
        end else begin
            r = req;
            if (m_phase == 2) r[m_win] = 1'b0;
            w = rr_pick(r, m_last);
            if (w >= 0) begin
                m_win = w; m_last = w; m_step = int'(steps[4*w +: 4]); m_phase = 1;
            end else begin
                m_phase = 0;
            end
        end
    endtask

    initial begin
        logic [3:0] e;
        i_rstn = 1'b0;
        i_req  = '0;
        i_step = '0;
        prev_count = '0;

        vecs[0] = '{req: 4'b0001, steps: 16'h0005, gnt: 4'b0001, count: 8'd5,  full: 1'b0};
        vecs[1] = '{req: 4'b1111, steps: 16'h2222, gnt: 4'b0010, count: 8'd7,  full: 1'b0};
        vecs[2] = '{req: 4'b1001, steps: 16'h4003, gnt: 4'b1000, count: 8'd11, full: 1'b0};
        vecs[3] = '{req: 4'b0110, steps: 16'h0900, gnt: 4'b0010, count: 8'd11, full: 1'b0};
        vecs[4] = '{req: 4'b0101, steps: 16'h0F0F, gnt: 4'b0100, count: 8'd26, full: 1'b0};
        vecs[5] = '{req: 4'b0001, steps: 16'h000F, gnt: 4'b0001, count: 8'd41, full: 1'b0};

        tick();
        tick();
        chk("rst_gnt", o_gnt, 0);
        chk("rst_ack", o_ack, 0);
        chk("rst_count", o_count, 0);
        chk("rst_full", o_full, 0);
        chk("rst_busy", o_busy, 0);
        i_rstn = 1'b1;

        // Table of single transactions from idle
        for (int v = 0; v < 6; v++) begin
            i_req  = vecs[v].req;
            i_step = vecs[v].steps;
            tick();
            chk("vec_gnt", o_gnt, vecs[v].gnt);
            chk("vec_busy_g", o_busy, 1);
            chk("vec_ack_g", o_ack, 0);
            tick();
            chk("vec_ack", o_ack, vecs[v].gnt);
            chk("vec_gnt_a", o_gnt, 0);
            chk("vec_count", o_count, vecs[v].count);
            chk("vec_full", o_full, vecs[v].full);
            i_req = '0;
            tick();
            chk("vec_busy_idle", o_busy, 0);
            chk("vec_ack_idle", o_ack, 0);
        end

        // Round-robin with all requesters held
        do_reset();
        i_req  = 4'b1111;
        i_step = 16'h1111;
        for (int g = 0; g < 5; g++) begin
            e = 4'b0001 << (g % N);
            tick();
            chk("rr_gnt", o_gnt, e);
            tick();
            chk("rr_ack", o_ack, e);
            chk("rr_count", o_count, g + 1);
            if (g == 4) i_req = '0;
        end
        tick();
        chk("rr_busy_end", o_busy, 0);

        // Fill to 250, then overflow and a further step while full
        do_reset();
        for (int k = 0; k < 17; k++) begin
            i_req  = 4'b0001;
            i_step = (k < 16) ? 16'h000F : 16'h000A;
            tick();
            tick();
            chk("fill_count", o_count, (k < 16) ? 15 * (k + 1) : 250);
            i_req = '0;
            tick();
        end
        i_req  = 4'b0001;
        i_step = 16'h000F;
        tick();
        tick();
        chk("sat_ack1", o_ack, 4'b0001);
        chk("sat_count1", o_count, SAT_EXP1);
        chk("sat_full1", o_full, SAT_FULL1);
        i_req = '0;
        tick();
        i_req  = 4'b0001;
        i_step = 16'h0003;
        tick();
        tick();
        chk("sat_ack2", o_ack, 4'b0001);
        chk("sat_count2", o_count, SAT_EXP2);
        chk("sat_full2", o_full, SAT_FULL2);
        i_req = '0;
        tick();

        // Request withdrawn during grant is still acked and applied
        do_reset();
        i_req  = 4'b0100;
        i_step = 16'h0700;
        tick();
        chk("drop_gnt", o_gnt, 4'b0100);
        i_req = '0;
        tick();
        chk("drop_ack", o_ack, 4'b0100);
        chk("drop_count", o_count, 7);
        tick();
        chk("drop_busy", o_busy, 0);

        // Reset while granting discards the update and never acks
        do_reset();
        i_req  = 4'b0010;
        i_step = 16'h0060;
        tick();
        chk("mid_gnt", o_gnt, 4'b0010);
        i_rstn = 1'b0;
        tick();
        chk("mid_rst_gnt", o_gnt, 0);
        chk("mid_rst_ack", o_ack, 0);
        chk("mid_rst_count", o_count, 0);
        chk("mid_rst_busy", o_busy, 0);
        i_rstn = 1'b1;
        i_req  = '0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("mid_no_ack", o_ack, 0);
            chk("mid_count0", o_count, 0);
        end

        // Requester 0 wins the first arbitration after reset
        i_req  = 4'b1111;
        i_step = 16'h0000;
        tick();
        chk("prio0_gnt", o_gnt, 4'b0001);
        i_req = '0;
        tick();
        tick();

        // Randomized traffic against the reference model
        i_rstn = 1'b0;
        i_req  = '0;
        model_advance(1'b0, 4'b0, 16'h0);
        tick();
        i_rstn = 1'b1;
        for (int c = 0; c < 800; c++) begin
            chk("rnd_gnt", o_gnt, (m_phase == 1) ? (4'b0001 << m_win) : 4'b0);
            chk("rnd_ack", o_ack, (m_phase == 2) ? (4'b0001 << m_win) : 4'b0);
            chk("rnd_count", o_count, m_count);
            chk("rnd_full", o_full, (m_count == MAXV) ? 1 : 0);
            chk("rnd_busy", o_busy, (m_phase != 0) ? 1 : 0);
            i_rstn = ($urandom_range(0, 99) != 0);
            for (int r = 0; r < N; r++) begin
                if (m_phase == 2 && m_win == r) begin
                    i_req[r] = 1'b0;
                end else if (!i_req[r] && $urandom_range(0, 3) == 0) begin
                    i_req[r] = 1'b1;
                    i_step[4*r +: 4] = 4'($urandom_range(0, 15));
                end
            end
            model_advance(i_rstn, i_req, i_step);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
